// File: rtl/tilelink_nto1_arbiter_if.sv
// ============================================================================
// Module   : tilelink_nto1_arbiter_if
// Brief    : Bundles the M upstream TL-UL A/D ports and the single downstream
//            TL-UL A/D port of the N-to-1 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tilelink_nto1_arbiter_if #(
    parameter int M     = 3,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int SW = TL_RS + IW;

    // Upstream A channel, master i at slice i
    logic [M-1:0][2:0]         master_a_opcode;
    logic [M-1:0][2:0]         master_a_param;
    logic [M-1:0][TL_SZ-1:0]   master_a_size;
    logic [M-1:0][TL_RS-1:0]   master_a_source;
    logic [M-1:0][TL_AW-1:0]   master_a_address;
    logic [M-1:0][TL_DW/8-1:0] master_a_mask;
    logic [M-1:0][TL_DW-1:0]   master_a_data;
    logic [M-1:0]              master_a_corrupt;
    logic [M-1:0]              master_a_valid;
    logic [M-1:0]              master_a_ready;

    // Upstream D channel
    logic [M-1:0][2:0]         master_d_opcode;
    logic [M-1:0][1:0]         master_d_param;
    logic [M-1:0][TL_SZ-1:0]   master_d_size;
    logic [M-1:0][TL_RS-1:0]   master_d_source;
    logic [M-1:0]              master_d_denied;
    logic [M-1:0][TL_DW-1:0]   master_d_data;
    logic [M-1:0]              master_d_corrupt;
    logic [M-1:0]              master_d_valid;
    logic [M-1:0]              master_d_ready;

    // Downstream A channel
    logic [2:0]                slave_a_opcode;
    logic [2:0]                slave_a_param;
    logic [TL_SZ-1:0]          slave_a_size;
    logic [SW-1:0]             slave_a_source;
    logic [TL_AW-1:0]          slave_a_address;
    logic [TL_DW/8-1:0]        slave_a_mask;
    logic [TL_DW-1:0]          slave_a_data;
    logic                      slave_a_corrupt;
    logic                      slave_a_valid;
    logic                      slave_a_ready;

    // Downstream D channel
    logic [2:0]                slave_d_opcode;
    logic [1:0]                slave_d_param;
    logic [TL_SZ-1:0]          slave_d_size;
    logic [SW-1:0]             slave_d_source;
    logic                      slave_d_denied;
    logic [TL_DW-1:0]          slave_d_data;
    logic                      slave_d_corrupt;
    logic                      slave_d_valid;
    logic                      slave_d_ready;

    // Arbiter view: it is the slave of the upstream masters
    modport slave (
        input  master_a_opcode, master_a_param, master_a_size, master_a_source,
               master_a_address, master_a_mask, master_a_data, master_a_corrupt,
               master_a_valid,
        output master_a_ready,
        output master_d_opcode, master_d_param, master_d_size, master_d_source,
               master_d_denied, master_d_data, master_d_corrupt, master_d_valid,
        input  master_d_ready,
        output slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
               slave_a_address, slave_a_mask, slave_a_data, slave_a_corrupt,
               slave_a_valid,
        input  slave_a_ready,
        input  slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
               slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid,
        output slave_d_ready
    );

    // Environment view: upstream masters plus the downstream decoder
    modport master (
        output master_a_opcode, master_a_param, master_a_size, master_a_source,
               master_a_address, master_a_mask, master_a_data, master_a_corrupt,
               master_a_valid,
        input  master_a_ready,
        input  master_d_opcode, master_d_param, master_d_size, master_d_source,
               master_d_denied, master_d_data, master_d_corrupt, master_d_valid,
        output master_d_ready,
        input  slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
               slave_a_address, slave_a_mask, slave_a_data, slave_a_corrupt,
               slave_a_valid,
        output slave_a_ready,
        output slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
               slave_d_denied, slave_d_data, slave_d_corrupt, slave_d_valid,
        input  slave_d_ready
    );
endinterface

`default_nettype wire

// File: rtl/tilelink_nto1_arbiter.sv
// ============================================================================
// Module   : tilelink_nto1_arbiter
// Brief    : M-to-1 TL-UL arbiter with registered A stage, burst lock for
//            multi-beat Put and source-tag routing of D responses.
// Config   : TL_NTO1_FIXED_PRIO_EN selects fixed lowest-index priority
//            instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tilelink_nto1_arbiter #(
    parameter int M     = 3,
    parameter int TL_DW = 32,
    parameter int TL_AW = 32,
    parameter int TL_RS = 4,
    parameter int TL_SZ = 4
) (
    input  logic                   tilelink_clock_i,
    input  logic                   tilelink_reset_i,
    tilelink_nto1_arbiter_if.slave bus,
    output logic                   decode_err_o
);
    localparam int IW     = (M > 1) ? $clog2(M) : 1;
    localparam int SW     = TL_RS + IW;
    localparam int LOG_BB = $clog2(TL_DW / 8);
    localparam int CW     = 12;
    localparam logic [IW:0] M_EXT = (IW + 1)'(M);

    logic                lock_q, lock_d;
    logic [IW-1:0]       lock_idx_q, lock_idx_d;
    logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
`ifndef TL_NTO1_FIXED_PRIO_EN
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
`endif
    logic                a_valid_q, a_valid_d;
    logic [2:0]          a_opcode_q;
    logic [2:0]          a_param_q;
    logic [TL_SZ-1:0]    a_size_q;
    logic [SW-1:0]       a_source_q;
    logic [TL_AW-1:0]    a_address_q;
    logic [TL_DW/8-1:0]  a_mask_q;
    logic [TL_DW-1:0]    a_data_q;
    logic                a_corrupt_q;
    logic                decode_err_q;

    logic [IW:0]         w_cand;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_gnt_any;
    logic [M-1:0]        w_grant;
    logic                w_can_load;
    logic                w_accept;
    logic                w_put_multi;
    logic [TL_SZ-1:0]    w_shift;
    logic [CW-1:0]       w_burst_cnt;
    logic [IW-1:0]       w_d_idx;
    logic                w_d_bad;

    // Grant: locked master only, else first requester scanning from the pointer
    always_comb begin
        w_cand    = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        if (lock_q) begin
            w_gnt_idx = lock_idx_q;
            w_gnt_any = 1'b1;
        end else begin
            for (int k = 0; k < M; k++) begin
`ifdef TL_NTO1_FIXED_PRIO_EN
                w_cand = (IW + 1)'(k);
`else
                w_cand = {1'b0, rr_ptr_q} + (IW + 1)'(k);
                if (w_cand >= M_EXT) begin
                    w_cand = w_cand - M_EXT;
                end
`endif
                if (!w_gnt_any && bus.master_a_valid[w_cand[IW-1:0]]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_cand[IW-1:0];
                end
            end
        end
    end

    assign w_grant    = w_gnt_any ? ({{(M-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
    assign w_can_load = !a_valid_q || bus.slave_a_ready;
    assign w_accept   = w_gnt_any && w_can_load && bus.master_a_valid[w_gnt_idx];

    assign bus.master_a_ready = w_grant & {M{w_can_load}};

    assign w_put_multi = ((bus.master_a_opcode[w_gnt_idx] == 3'd0) ||
                          (bus.master_a_opcode[w_gnt_idx] == 3'd1)) &&
                         (bus.master_a_size[w_gnt_idx] > TL_SZ'(LOG_BB));
    assign w_shift     = bus.master_a_size[w_gnt_idx] - TL_SZ'(LOG_BB);
    assign w_burst_cnt = (CW'(1) << w_shift) - CW'(1);

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        a_valid_d  = w_can_load ? w_accept : a_valid_q;
`ifndef TL_NTO1_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (w_accept) begin
            if (lock_q) begin
                beat_cnt_d = beat_cnt_q - CW'(1);
                if (beat_cnt_q == CW'(1)) begin
                    lock_d = 1'b0;
                end
            end else begin
`ifndef TL_NTO1_FIXED_PRIO_EN
                rr_ptr_d = (w_gnt_idx == IW'(M - 1)) ? '0 : w_gnt_idx + IW'(1);
`endif
                if (w_put_multi) begin
                    lock_d     = 1'b1;
                    lock_idx_d = w_gnt_idx;
                    beat_cnt_d = w_burst_cnt;
                end
            end
        end
    end

    always_ff @(posedge tilelink_clock_i or posedge tilelink_reset_i) begin
        if (tilelink_reset_i) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            beat_cnt_q   <= '0;
            a_valid_q    <= 1'b0;
            decode_err_q <= 1'b0;
`ifndef TL_NTO1_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            a_valid_q    <= a_valid_d;
            decode_err_q <= decode_err_q | (bus.slave_d_valid & w_d_bad);
`ifndef TL_NTO1_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    // Payload needs no reset: it is only observed while a_valid_q is set
    always_ff @(posedge tilelink_clock_i) begin
        if (w_accept) begin
            a_opcode_q  <= bus.master_a_opcode[w_gnt_idx];
            a_param_q   <= bus.master_a_param[w_gnt_idx];
            a_size_q    <= bus.master_a_size[w_gnt_idx];
            a_source_q  <= {w_gnt_idx, bus.master_a_source[w_gnt_idx]};
            a_address_q <= bus.master_a_address[w_gnt_idx];
            a_mask_q    <= bus.master_a_mask[w_gnt_idx];
            a_data_q    <= bus.master_a_data[w_gnt_idx];
            a_corrupt_q <= bus.master_a_corrupt[w_gnt_idx];
        end
    end

    assign bus.slave_a_valid   = a_valid_q;
    assign bus.slave_a_opcode  = a_opcode_q;
    assign bus.slave_a_param   = a_param_q;
    assign bus.slave_a_size    = a_size_q;
    assign bus.slave_a_source  = a_source_q;
    assign bus.slave_a_address = a_address_q;
    assign bus.slave_a_mask    = a_mask_q;
    assign bus.slave_a_data    = a_data_q;
    assign bus.slave_a_corrupt = a_corrupt_q;

    // D routing by the index tag; an out-of-range tag is swallowed
    assign w_d_idx = bus.slave_d_source[SW-1:TL_RS];
    assign w_d_bad = ({1'b0, w_d_idx} >= M_EXT);

    always_comb begin
        bus.master_d_valid   = '0;
        bus.master_d_opcode  = '0;
        bus.master_d_param   = '0;
        bus.master_d_size    = '0;
        bus.master_d_source  = '0;
        bus.master_d_denied  = '0;
        bus.master_d_data    = '0;
        bus.master_d_corrupt = '0;
        for (int j = 0; j < M; j++) begin
            bus.master_d_valid[j]   = bus.slave_d_valid && (w_d_idx == IW'(j));
            bus.master_d_opcode[j]  = bus.slave_d_opcode;
            bus.master_d_param[j]   = bus.slave_d_param;
            bus.master_d_size[j]    = bus.slave_d_size;
            bus.master_d_source[j]  = bus.slave_d_source[TL_RS-1:0];
            bus.master_d_denied[j]  = bus.slave_d_denied;
            bus.master_d_data[j]    = bus.slave_d_data;
            bus.master_d_corrupt[j] = bus.slave_d_corrupt;
        end
    end

    assign bus.slave_d_ready = w_d_bad || bus.master_d_ready[w_d_idx];
    assign decode_err_o      = decode_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tilelink_nto1_arbiter.sv
// ============================================================================
// Module   : tb_tilelink_nto1_arbiter
// Brief    : Self-checking bench: transaction-level reference model of the
//            arbiter driven by directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tilelink_nto1_arbiter;
    localparam int M      = 3;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int RS     = 4;
    localparam int SZ     = 4;
    localparam int IW     = $clog2(M);
    localparam int SW     = RS + IW;
    localparam int LOG_BB = $clog2(DW / 8);

    typedef struct packed {
        logic [2:0]        opcode;
        logic [2:0]        param;
        logic [SZ-1:0]     size;
        logic [RS-1:0]     source;
        logic [AW-1:0]     address;
        logic [DW/8-1:0]   mask;
        logic [DW-1:0]     data;
        logic              corrupt;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic decode_err;

    always #5 clk = ~clk;

    tilelink_nto1_arbiter_if #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) bus ();

    tilelink_nto1_arbiter #(.M(M), .TL_DW(DW), .TL_AW(AW), .TL_RS(RS), .TL_SZ(SZ)) dut (
        .tilelink_clock_i (clk),
        .tilelink_reset_i (rst),
        .bus              (bus),
        .decode_err_o     (decode_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs
    int p_val  = 100;
    int p_srdy = 100;
    int p_new  = 0;
    bit d_rand = 0;
    int srdy_pat[$];

    // Upstream master state: beats left in the current transaction
    int    m_left[M];
    bit    m_valid[M];
    beat_t m_beat[M];

    // Reference model
    bit    md_out_valid;
    beat_t md_out;
    int    md_out_idx;
    int    md_ptr;
    bit    md_locked;
    int    md_lock_idx;
    int    md_left;
    bit    md_err;

    logic [SW-1:0] obs_src[$];
    int            rdy_pulses[M];

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic start_txn(input int i, input logic [2:0] op, input logic [SZ-1:0] sz,
                             input logic [RS-1:0] src);
        m_beat[i].opcode  = op;
        m_beat[i].param   = 3'($urandom_range(7));
        m_beat[i].size    = sz;
        m_beat[i].source  = src;
        m_beat[i].address = $urandom;
        m_beat[i].corrupt = 1'b0;
        m_left[i]  = (op != 3'd4 && int'(sz) > LOG_BB) ? (1 << sz) / (DW / 8) : 1;
        m_valid[i] = 1'b0;
    endtask

    task automatic drive_masters();
        for (int i = 0; i < M; i++) begin
            bus.master_a_valid[i]   = m_valid[i];
            bus.master_a_opcode[i]  = m_beat[i].opcode;
            bus.master_a_param[i]   = m_beat[i].param;
            bus.master_a_size[i]    = m_beat[i].size;
            bus.master_a_source[i]  = m_beat[i].source;
            bus.master_a_address[i] = m_beat[i].address;
            bus.master_a_mask[i]    = m_beat[i].mask;
            bus.master_a_data[i]    = m_beat[i].data;
            bus.master_a_corrupt[i] = m_beat[i].corrupt;
        end
    endtask

    function automatic logic [2:0] pick_op();
        case ($urandom_range(2))
            0:       return 3'd0;
            1:       return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance model after the edge
    task automatic run_cycle();
        int g;
        bit can_load, acc, d_bad;
        int didx;
        logic [M-1:0] exp_rdy, exp_dv;
        logic [SW-1:0] exp_src;

        for (int i = 0; i < M; i++) begin
            if (p_new > 0 && m_left[i] == 0 && $urandom_range(99) < p_new)
                start_txn(i, pick_op(), SZ'($urandom_range(4)), RS'($urandom_range(15)));
            if (m_left[i] > 0 && !m_valid[i] && $urandom_range(99) < p_val) begin
                m_valid[i]        = 1'b1;
                m_beat[i].data    = $urandom;
                m_beat[i].mask    = 4'($urandom_range(15));
            end
        end
        drive_masters();
        if (srdy_pat.size() > 0) bus.slave_a_ready = 1'(srdy_pat.pop_front());
        else                     bus.slave_a_ready = ($urandom_range(99) < p_srdy);
        if (d_rand) begin
            bus.slave_d_valid   = 1'($urandom_range(1));
            bus.slave_d_source  = {IW'($urandom_range(M - 1)), RS'($urandom)};
            bus.slave_d_data    = $urandom;
            bus.slave_d_opcode  = 3'($urandom);
            bus.master_d_ready  = M'($urandom);
        end

        @(negedge clk);
        g = -1;
        if (md_locked) g = md_lock_idx;
        else for (int k = 0; k < M; k++) begin
            int j = (md_ptr + k) % M;
            if (g < 0 && m_valid[j]) g = j;
        end
        can_load = !md_out_valid || bus.slave_a_ready;
        exp_rdy  = '0;
        if (g >= 0 && can_load) exp_rdy[g] = 1'b1;
        acc = (g >= 0) && can_load && m_valid[g];

        check_eq("a_ready", bus.master_a_ready, exp_rdy);
        check_eq("a_valid", bus.slave_a_valid, md_out_valid);
        if (md_out_valid) begin
            exp_src = {IW'(md_out_idx), md_out.source};
            check_eq("a_source", bus.slave_a_source, exp_src);
            check_eq("a_payload",
                     {bus.slave_a_opcode, bus.slave_a_param, bus.slave_a_size, bus.slave_a_address,
                      bus.slave_a_mask, bus.slave_a_data, bus.slave_a_corrupt},
                     {md_out.opcode, md_out.param, md_out.size, md_out.address,
                      md_out.mask, md_out.data, md_out.corrupt});
        end
        if (bus.slave_a_valid && bus.slave_a_ready) obs_src.push_back(bus.slave_a_source);
        for (int i = 0; i < M; i++) if (bus.master_a_ready[i]) rdy_pulses[i]++;

        didx   = int'(bus.slave_d_source[SW-1:RS]);
        d_bad  = (didx >= M);
        exp_dv = '0;
        if (bus.slave_d_valid && !d_bad) exp_dv[didx] = 1'b1;
        check_eq("d_valid", bus.master_d_valid, exp_dv);
        check_eq("d_ready", bus.slave_d_ready, d_bad ? 1'b1 : bus.master_d_ready[didx]);
        check_eq("d_source", bus.master_d_source, {M{bus.slave_d_source[RS-1:0]}});
        check_eq("d_data", bus.master_d_data, {M{bus.slave_d_data}});
        check_eq("decode_err", decode_err, md_err);

        @(posedge clk);
        #1;
        if (acc) begin
            if (md_locked) begin
                md_left--;
                if (md_left == 0) md_locked = 1'b0;
            end else begin
`ifndef TL_NTO1_FIXED_PRIO_EN
                md_ptr = (g + 1) % M;
`endif
                if ((m_beat[g].opcode == 3'd0 || m_beat[g].opcode == 3'd1) &&
                    int'(m_beat[g].size) > LOG_BB) begin
                    md_locked   = 1'b1;
                    md_lock_idx = g;
                    md_left     = (1 << m_beat[g].size) / (DW / 8) - 1;
                end
            end
        end
        if (can_load) begin
            md_out_valid = acc;
            if (acc) begin
                md_out     = m_beat[g];
                md_out_idx = g;
            end
        end
        if (bus.slave_d_valid && d_bad) md_err = 1'b1;
        if (acc) begin
            m_valid[g] = 1'b0;
            m_left[g]--;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_a_valid", bus.slave_a_valid, 1'b0);
        check_eq("rst_err", decode_err, 1'b0);
        for (int i = 0; i < M; i++) begin
            m_left[i]  = 0;
            m_valid[i] = 1'b0;
        end
        drive_masters();
        bus.slave_d_valid = 1'b0;
        md_out_valid = 1'b0;
        md_ptr       = 0;
        md_locked    = 1'b0;
        md_left      = 0;
        md_err       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [SW-1:0] exp_t2[3];
        rst = 1'b1;
        for (int i = 0; i < M; i++) begin
            m_beat[i]  = '0;
            m_left[i]  = 0;
            m_valid[i] = 1'b0;
        end
        drive_masters();
        bus.slave_a_ready   = 1'b1;
        bus.slave_d_valid   = 1'b0;
        bus.slave_d_opcode  = '0;
        bus.slave_d_param   = '0;
        bus.slave_d_size    = '0;
        bus.slave_d_source  = '0;
        bus.slave_d_denied  = 1'b0;
        bus.slave_d_data    = '0;
        bus.slave_d_corrupt = 1'b0;
        bus.master_d_ready  = '1;

        // Reset then idle
        do_reset();
        repeat (3) run_cycle();

        // Three simultaneous Gets, served in rotation
        obs_src.delete();
        for (int i = 0; i < M; i++) rdy_pulses[i] = 0;
        for (int i = 0; i < M; i++) start_txn(i, 3'd4, 4'd2, 4'd5);
        repeat (5) run_cycle();
        exp_t2[0] = 6'h05; exp_t2[1] = 6'h15; exp_t2[2] = 6'h25;
        check_eq("t2_count", obs_src.size(), 3);
        for (int k = 0; k < 3; k++)
            check_eq("t2_src", (k < obs_src.size()) ? obs_src[k] : '1, exp_t2[k]);
        for (int i = 0; i < M; i++) check_eq("t2_rdy_pulses", rdy_pulses[i], 1);

        // Four-beat Put from master 1 holds the grant against master 0
        obs_src.delete();
        start_txn(1, 3'd0, 4'd4, 4'd3);
        run_cycle();
        start_txn(0, 3'd4, 4'd2, 4'd7);
        repeat (8) run_cycle();
        check_eq("t3_count", obs_src.size(), 5);
        for (int k = 0; k < 5; k++)
            check_eq("t3_idx", (k < obs_src.size()) ? obs_src[k][SW-1:RS] : '1,
                     (k < 4) ? IW'(1) : IW'(0));

        // Output backpressure for three cycles in the middle of a burst
        obs_src.delete();
        start_txn(2, 3'd1, 4'd4, 4'd9);
        srdy_pat = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        repeat (12) run_cycle();
        check_eq("t4_count", obs_src.size(), 4);

        // D routed to master 2 with its ready low then high
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 6'h23;
        bus.slave_d_data   = 32'hCAFE_0123;
        bus.master_d_ready = 3'b011;
        run_cycle();
        check_eq("t5_dvalid", bus.master_d_valid, 3'b100);
        check_eq("t5_dsrc", bus.master_d_source[2], 4'h3);
        check_eq("t5_rdy0", bus.slave_d_ready, 1'b0);
        bus.master_d_ready = 3'b111;
        run_cycle();
        check_eq("t5_rdy1", bus.slave_d_ready, 1'b1);
        bus.slave_d_valid = 1'b0;

        // Random traffic on both channels
        p_val = 60; p_srdy = 70; p_new = 30; d_rand = 1;
        repeat (1500) run_cycle();
        p_val = 100; p_srdy = 100; p_new = 0; d_rand = 0;

        // Reset in the middle of a burst; the burst restarts from scratch
        do_reset();
        start_txn(0, 3'd0, 4'd4, 4'd1);
        repeat (2) run_cycle();
        do_reset();
        obs_src.delete();
        start_txn(0, 3'd0, 4'd4, 4'd1);
        start_txn(1, 3'd4, 4'd2, 4'd9);
        repeat (8) run_cycle();
        check_eq("rb_count", obs_src.size(), 5);
        check_eq("rb_first", (obs_src.size() > 0) ? obs_src[0][SW-1:RS] : '1, IW'(0));
        check_eq("rb_last", (obs_src.size() > 4) ? obs_src[4][SW-1:RS] : '1, IW'(1));

        // Out-of-range tag: dropped and flagged from the next cycle on
        bus.slave_d_valid  = 1'b1;
        bus.slave_d_source = 6'h33;
        bus.master_d_ready = 3'b000;
        run_cycle();
        check_eq("t6_dvalid", bus.master_d_valid, 3'b000);
        check_eq("t6_rdy", bus.slave_d_ready, 1'b1);
        bus.slave_d_valid  = 1'b0;
        bus.slave_d_source = 6'h00;
        bus.master_d_ready = 3'b111;
        repeat (2) run_cycle();
        check_eq("t6_err", decode_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
